// File: rtl/mvb_master_scheduler.sv
// MVB bus-administrator poll sequencer: one master frame per table entry per macro period.
// Build option: define SCHED_STATS_EN to add saturating timeout/error counters (cnt_timeout/cnt_error).
module mvb_master_scheduler #(
    parameter int unsigned NUM_PORTS     = 8,
    parameter int unsigned CLK_PER_US    = 100,
    parameter int unsigned PERIOD_US     = 1000,
    parameter int unsigned SEND_HOLD     = 30,
    parameter int unsigned REPLY_TIMEOUT = 4000
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         enable,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_PORTS)-1:0] cfg_addr,
    input  logic [15:0]                  cfg_data,
    output logic [15:0]                  enc_data,
    output logic                         enc_fifo_we,
    output logic [6:0]                   enc_frame_length,
    output logic                         enc_m_frame,
    output logic                         enc_s_frame,
    output logic                         enc_send_frame,
    input  logic                         enc_frame_over,
    input  logic                         dec_frame_over,
    input  logic                         dec_error,
    output logic                         busy,
    output logic                         cycle_start,
    output logic                         overrun,
    output logic                         stat_valid,
    output logic [$clog2(NUM_PORTS)-1:0] stat_index,
`ifdef SCHED_STATS_EN
    output logic [15:0]                  cnt_timeout,
    output logic [15:0]                  cnt_error,
`endif
    output logic [1:0]                   stat_code
);

    localparam int unsigned IW = $clog2(NUM_PORTS);
    localparam logic [15:0] PRE_MAX  = 16'(CLK_PER_US - 1);
    localparam logic [15:0] PER_MAX  = 16'(PERIOD_US - 1);
    localparam logic [15:0] HOLD_MAX = 16'(SEND_HOLD - 1);
    localparam logic [15:0] TMO_MAX  = 16'(REPLY_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StFetch, StLoad, StSend, StWaitTx, StWaitRx, StRecord, StNext, StEnd
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   table_q [NUM_PORTS];
    logic [15:0]   pre_q, per_q;
    logic          flag_q, flag_clr, period_tick, end_wait_q;
    logic [2:0]    efo_sync, dfo_sync;
    logic [1:0]    err_sync;
    logic          tx_edge, rx_edge;
    logic [15:0]   entry;

    // Third flop of each chain only remembers the previous synchronised value for edge detection.
    assign tx_edge     = efo_sync[1] & ~efo_sync[2];
    assign rx_edge     = dfo_sync[1] & ~dfo_sync[2];
    assign entry       = table_q[idx_q];
    assign period_tick = enable && (pre_q == PRE_MAX) && (per_q == PER_MAX);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            efo_sync <= '0;
            dfo_sync <= '0;
            err_sync <= '0;
        end else begin
            efo_sync <= {efo_sync[1:0], enc_frame_over};
            dfo_sync <= {dfo_sync[1:0], dec_frame_over};
            err_sync <= {err_sync[0], dec_error};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PORTS; i++) table_q[i] <= 16'hF000;
        end else if (cfg_we) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_q  <= '0;
            per_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (enable) begin
                if (pre_q == PRE_MAX) begin
                    pre_q <= '0;
                    per_q <= (per_q == PER_MAX) ? 16'd0 : per_q + 16'd1;
                end else begin
                    pre_q <= pre_q + 16'd1;
                end
            end
            // A fresh period tick wins over a clear in the same cycle.
            flag_q <= (flag_q & ~flag_clr) | period_tick;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            data_q     <= '0;
            end_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            data_q     <= data_d;
            end_wait_q <= (state_q == StEnd);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        data_d   = data_q;
        flag_clr = 1'b0;
        case (state_q)
            StIdle:   if (enable) state_d = StStart;
            StStart: begin
                idx_d   = '0;
                state_d = StFetch;
            end
            StFetch: begin
                if (entry[15:12] == 4'hF) begin
                    state_d = StNext;
                end else begin
                    data_d  = entry;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad, StSend: begin
                if (cnt_q == HOLD_MAX) begin
                    cnt_d   = '0;
                    state_d = (state_q == StLoad) ? StSend : StWaitTx;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitTx: begin
                if (tx_edge) begin
                    cnt_d   = '0;
                    state_d = StWaitRx;
                end else if (cnt_q == TMO_MAX) begin
                    code_d  = 2'b01;
                    state_d = StRecord;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitRx: begin
                // Frame reception takes priority over a coincident timeout.
                if (rx_edge) begin
                    code_d  = err_sync[1] ? 2'b10 : 2'b00;
                    state_d = StRecord;
                end else if (cnt_q == TMO_MAX) begin
                    code_d  = 2'b01;
                    state_d = StRecord;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRecord: state_d = StNext;
            StNext: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (idx_q == IW'(NUM_PORTS - 1)) begin
                    state_d = StEnd;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = StFetch;
                end
            end
            StEnd: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (flag_q) begin
                    flag_clr = 1'b1;
                    state_d  = StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Overrun only when the flag was already set on the first END cycle.
    assign overrun          = (state_q == StEnd) && enable && flag_q && !end_wait_q;
    assign busy             = (state_q != StIdle) && (state_q != StEnd);
    assign cycle_start      = (state_q == StStart);
    assign enc_fifo_we      = (state_q == StLoad);
    assign enc_send_frame   = (state_q == StSend);
    assign enc_m_frame      = (state_q == StLoad) || (state_q == StSend);
    assign enc_s_frame      = 1'b0;
    assign enc_frame_length = busy ? 7'd1 : 7'd0;
    assign enc_data         = data_q;
    assign stat_valid       = (state_q == StRecord);
    assign stat_index       = idx_q;
    assign stat_code        = code_q;

`ifdef SCHED_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_timeout <= '0;
            cnt_error   <= '0;
        end else if (state_q == StRecord) begin
            if (code_q == 2'b01 && cnt_timeout != 16'hFFFF) cnt_timeout <= cnt_timeout + 16'd1;
            if (code_q == 2'b10 && cnt_error != 16'hFFFF) cnt_error <= cnt_error + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mvb_master_scheduler.sv
// Directed self-checking bench for mvb_master_scheduler (main instance plus a short-period instance).
module tb_mvb_master_scheduler;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        enable = 1'b0, b_enable = 1'b0;
    logic        cfg_we = 1'b0, b_cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        enc_frame_over = 1'b0, dec_frame_over = 1'b0, dec_error = 1'b0;
    logic        b_zero = 1'b0;

    logic [15:0] enc_data, b_enc_data;
    logic        enc_fifo_we, enc_m_frame, enc_s_frame, enc_send_frame;
    logic        b_enc_fifo_we, b_enc_m_frame, b_enc_s_frame, b_enc_send_frame;
    logic [6:0]  enc_frame_length, b_enc_frame_length;
    logic        busy, cycle_start, overrun, stat_valid;
    logic        b_busy, b_cycle_start, b_overrun, b_stat_valid;
    logic [2:0]  stat_index, b_stat_index;
    logic [1:0]  stat_code, b_stat_code;
`ifdef SCHED_STATS_EN
    logic [15:0] cnt_timeout, cnt_error, b_cnt_timeout, b_cnt_error;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_a = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (overrun === 1'b1) ovr_a <= ovr_a + 1;

    mvb_master_scheduler #(
        .NUM_PORTS(8), .CLK_PER_US(10), .PERIOD_US(1000), .SEND_HOLD(30), .REPLY_TIMEOUT(4000)
    ) dut (
        .CLK(clk), .RESET(RESET), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .enc_data(enc_data), .enc_fifo_we(enc_fifo_we),
        .enc_frame_length(enc_frame_length), .enc_m_frame(enc_m_frame),
        .enc_s_frame(enc_s_frame), .enc_send_frame(enc_send_frame),
        .enc_frame_over(enc_frame_over), .dec_frame_over(dec_frame_over),
        .dec_error(dec_error), .busy(busy), .cycle_start(cycle_start), .overrun(overrun),
        .stat_valid(stat_valid), .stat_index(stat_index),
`ifdef SCHED_STATS_EN
        .cnt_timeout(cnt_timeout), .cnt_error(cnt_error),
`endif
        .stat_code(stat_code)
    );

    // Short period and short timeouts so a full scan overruns the 10 us period.
    mvb_master_scheduler #(
        .NUM_PORTS(8), .CLK_PER_US(10), .PERIOD_US(10), .SEND_HOLD(4), .REPLY_TIMEOUT(40)
    ) dut_b (
        .CLK(clk), .RESET(RESET), .enable(b_enable), .cfg_we(b_cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .enc_data(b_enc_data), .enc_fifo_we(b_enc_fifo_we),
        .enc_frame_length(b_enc_frame_length), .enc_m_frame(b_enc_m_frame),
        .enc_s_frame(b_enc_s_frame), .enc_send_frame(b_enc_send_frame),
        .enc_frame_over(b_zero), .dec_frame_over(b_zero), .dec_error(b_zero),
        .busy(b_busy), .cycle_start(b_cycle_start), .overrun(b_overrun),
        .stat_valid(b_stat_valid), .stat_index(b_stat_index),
`ifdef SCHED_STATS_EN
        .cnt_timeout(b_cnt_timeout), .cnt_error(b_cnt_error),
`endif
        .stat_code(b_stat_code)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return enc_fifo_we;
            1:       return enc_send_frame;
            2:       return stat_valid;
            3:       return cycle_start;
            4:       return ~busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input int limit, output int n);
        n = 0;
        while (sig(w) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, 32'(n < limit), 32'd1);
    endtask

    task automatic cfg_write(input bit to_b, input logic [2:0] a, input logic [15:0] d);
        cfg_addr = a;
        cfg_data = d;
        if (to_b) b_cfg_we = 1'b1; else cfg_we = 1'b1;
        tick(1);
        cfg_we   = 1'b0;
        b_cfg_we = 1'b0;
    endtask

    // Plays encoder/decoder for one polled entry and checks the strobes and the reported status.
    task automatic serve(input logic [15:0] ed, input int ix, input bit err, input bit tmo,
                         input bit drop);
        int n;
        wait_for("we_rise", 0, 6000, n);
        check("enc_data", 32'(enc_data), 32'(ed));
        check("m_frame_load", 32'(enc_m_frame), 32'd1);
        check("frame_len", 32'(enc_frame_length), 32'd1);
        n = 0;
        while (enc_fifo_we === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("we_hold", 32'(n), 32'd30);
        check("send_follows", 32'(enc_send_frame), 32'd1);
        check("m_frame_send", 32'(enc_m_frame), 32'd1);
        n = 0;
        while (enc_send_frame === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_hold", 32'(n), 32'd30);
        check("m_frame_off", 32'(enc_m_frame), 32'd0);
        tick(10);
        enc_frame_over = 1'b1;
        if (tmo) begin
            // 2 sync flops + 1 cycle into WAIT_RX + 4000 timeout cycles.
            wait_for("tmo_stat", 2, 5000, n);
            check("tmo_latency", 32'(n), 32'd4003);
            enc_frame_over = 1'b0;
        end else begin
            tick(4);
            enc_frame_over = 1'b0;
            if (drop) begin
                tick(96);
                enable = 1'b0;
                tick(100);
            end else begin
                tick(196);
            end
            dec_frame_over = 1'b1;
            dec_error      = err;
            wait_for("rx_stat", 2, 20, n);
            check("rx_latency", 32'(n), 32'd3);
        end
        check("stat_index", 32'(stat_index), 32'(ix));
        check("stat_code", 32'(stat_code), tmo ? 32'd1 : (err ? 32'd2 : 32'd0));
        dec_frame_over = 1'b0;
        dec_error      = 1'b0;
    endtask

    initial begin
        int n, sv, t0;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(enc_fifo_we), 32'd0);
        check("rst_data", 32'(enc_data), 32'd0);
        check("rst_len", 32'(enc_frame_length), 32'd0);
        check("rst_stat", 32'({stat_valid, stat_index, stat_code}), 32'd0);
        check("rst_pulses", 32'({cycle_start, overrun, enc_s_frame, enc_m_frame}), 32'd0);
        RESET = 1'b1;
        tick(2);

        // Overrun: 8 timing-out entries take far longer than a 100-cycle period.
        for (int i = 0; i < 8; i++) cfg_write(1'b1, 3'(i), 16'h1000 + 16'(i));
        b_enable = 1'b1;
        n = 0;
        while (b_cycle_start !== 1'b1 && n < 10) begin tick(1); n++; end
        check("b_start_seen", 32'(n < 10), 32'd1);
        tick(1);
        n = 0; sv = 0;
        while (b_overrun !== 1'b1 && n < 3000) begin
            if (b_stat_valid === 1'b1) sv++;
            tick(1);
            n++;
        end
        check("b_overrun_seen", 32'(n < 3000), 32'd1);
        check("b_stat_count", 32'(sv), 32'd8);
        check("b_last_code", 32'(b_stat_code), 32'd1);
        check("b_end_busy", 32'(b_busy), 32'd0);
        tick(1);
        check("b_restart", 32'(b_cycle_start), 32'd1);
        check("b_restart_busy", 32'(b_busy), 32'd1);
        check("b_overrun_pulse", 32'(b_overrun), 32'd0);
        b_enable = 1'b0;

        // Normal scan of entries 0 and 1.
        cfg_write(1'b0, 3'd0, 16'h3012);
        cfg_write(1'b0, 3'd1, 16'h4020);
        enable = 1'b1;
        wait_for("start1", 3, 5, n);
        t0 = cyc;
        check("start_idx", 32'(stat_index), 32'd0);
        serve(16'h3012, 0, 1'b0, 1'b0, 1'b0);
        serve(16'h4020, 1, 1'b0, 1'b0, 1'b0);
        wait_for("end1", 4, 50, n);
        cfg_write(1'b0, 3'd2, 16'h1005);
        wait_for("start2", 3, 12000, n);
        check("period1", 32'(cyc - t0), 32'd10000);
        t0 = cyc;

        // Error reply, normal reply, then decoder silent on entry 2.
        serve(16'h3012, 0, 1'b1, 1'b0, 1'b0);
`ifdef SCHED_STATS_EN
        tick(1);
        check("cnt_error", 32'(cnt_error), 32'd1);
`endif
        serve(16'h4020, 1, 1'b0, 1'b0, 1'b0);
        serve(16'h1005, 2, 1'b0, 1'b1, 1'b0);
`ifdef SCHED_STATS_EN
        tick(1);
        check("cnt_timeout", 32'(cnt_timeout), 32'd1);
`endif
        wait_for("start3", 3, 12000, n);
        check("period2", 32'(cyc - t0), 32'd10000);
        check("no_overrun", 32'(ovr_a), 32'd0);

        // enable dropped while entry 1 waits for its reply.
        serve(16'h3012, 0, 1'b0, 1'b0, 1'b0);
        serve(16'h4020, 1, 1'b0, 1'b0, 1'b1);
        wait_for("idle_after_drop", 4, 10, n);
        sv = 0;
        repeat (300) begin
            if (enc_fifo_we === 1'b1 || busy === 1'b1) sv++;
            tick(1);
        end
        check("quiet_after_drop", 32'(sv), 32'd0);

        // Reset asserted mid-SEND.
        enable = 1'b1;
        wait_for("start4", 3, 5, n);
        wait_for("send4", 1, 200, n);
        tick(5);
        RESET = 1'b0;
        #1;
        check("arst_send", 32'({enc_send_frame, enc_fifo_we, enc_m_frame}), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", 32'(enc_data), 32'd0);
        check("arst_len", 32'(enc_frame_length), 32'd0);
        check("arst_stat", 32'({stat_valid, stat_index, stat_code}), 32'd0);
        tick(2);
        RESET = 1'b1;
        wait_for("start5", 3, 5, n);
        check("restart_idx", 32'(stat_index), 32'd0);
        n = 0; sv = 0;
        while (busy !== 1'b0 && n < 50) begin
            if (enc_fifo_we === 1'b1) sv++;
            tick(1);
            n++;
        end
        check("cleared_scan_done", 32'(n < 50), 32'd1);
        check("cleared_table_no_we", 32'(sv), 32'd0);
`ifdef SCHED_STATS_EN
        check("cnt_error_rst", 32'(cnt_error), 32'd0);
`endif
        enable = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvb_master_scheduler.md
Name: mvb_master_scheduler

Overview:
- Bus-administrator poll sequencer for the MVB link: cycles through a programmable table of port entries once per macro period.
- For each entry it loads one master-frame word into the encoder FIFO, triggers transmission, then waits for the slave reply from the decoder or a timeout.
- Sits between the CPU GPIO configuration path and the Encode/decode pair, replacing the hand-timed send_frame/write_en test logic.
- Reports a per-entry status.

Parameters:
- NUM_PORTS, 8, table depth (power of two, 2..16)
- CLK_PER_US, 100, CLK cycles per microsecond tick
- PERIOD_US, 1000, macro period in microseconds (16-bit)
- SEND_HOLD, 30, CLK cycles each encoder strobe is held, for capture by the 24/3 MHz domain
- REPLY_TIMEOUT, 4000, CLK cycles allowed from TX frame end to RX frame end

Ports:
- CLK  in  1  system clock (100 MHz)
- RESET  in  1  asynchronous active-low reset
- enable  in  1  scheduler run enable
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(NUM_PORTS)  table index
- cfg_data  in  16  entry: [15:12] F-code, [11:0] port address; F-code 4'hF = skip
- enc_data  out  16  master-frame word to encoder FIFO
- enc_fifo_we  out  1  encoder FIFO write enable
- enc_frame_length  out  7  frame length in words, always 7'd1 while active
- enc_m_frame  out  1  master-frame select
- enc_s_frame  out  1  slave-frame select, tied 0
- enc_send_frame  out  1  transmit trigger
- enc_frame_over  in  1  encoder TX-done level/pulse, async to CLK
- dec_frame_over  in  1  decoder RX-done, async to CLK
- dec_error  in  1  OR of decoder length/signal/delimiter/quality/crc errors, async
- busy  out  1  scan in progress
- cycle_start  out  1  one-cycle pulse at each scan start
- overrun  out  1  one-cycle pulse when a scan ends after its period has elapsed
- stat_valid  out  1  one-cycle status strobe
- stat_index  out  $clog2(NUM_PORTS)  entry reported
- stat_code  out  2  00 ok, 01 timeout, 10 CRC/format error

Behaviour:
- Reset (async, RESET=0): state IDLE; all outputs 0 except enc_frame_length = 0. Table contents are cleared to 16'hF000 (all entries skipped).
- Table writes are accepted in any state and take effect when the entry is next fetched.
- Synchronisation: enc_frame_over, dec_frame_over and dec_error each pass through a 2-flop synchroniser. Only rising edges of the synchronised frame_over signals count as events.
- Timebase: the microsecond prescaler and period counter run whenever enable = 1. A period-elapsed flag is set when the counter reaches PERIOD_US-1; the counter then wraps to 0.
- FSM states and transitions:
  - IDLE: when enable = 1, go to START.
  - START: pulse cycle_start; set idx = 0; go to FETCH.
  - FETCH: if F-code = F, go to NEXT; otherwise latch enc_data = {F-code, addr} and go to LOAD.
  - LOAD: enc_fifo_we = 1 and enc_m_frame = 1 for SEND_HOLD cycles; then go to SEND.
  - SEND: enc_send_frame = 1 for SEND_HOLD cycles; then go to WAIT_TX.
  - WAIT_TX: on an enc_frame_over edge, clear the timeout counter and go to WAIT_RX.
  - WAIT_RX: on a dec_frame_over edge, code = dec_error ? 10 : 00. If the counter reaches REPLY_TIMEOUT-1 first, code = 01. Either way go to RECORD.
  - RECORD: stat_valid pulse with stat_index = idx and stat_code; go to NEXT.
  - NEXT: if idx = NUM_PORTS-1, go to END; otherwise idx+1 and go to FETCH.
  - END: if enable = 0, go to IDLE. Otherwise, if the period-elapsed flag is already set, pulse overrun, clear the flag and go to START. Otherwise wait in END for the flag, then clear it and go to START.
- The WAIT_TX timeout also uses REPLY_TIMEOUT. On expiry it reports code 01 and skips WAIT_RX.
- An edge arriving in any state other than WAIT_TX/WAIT_RX is discarded.
- A simultaneous dec_frame_over edge and timeout resolves as a received frame.
- enable falling mid-scan: the current entry completes through RECORD, then the FSM goes to IDLE; the remaining entries are not polled.
- busy = 1 in every state except IDLE and END.
- enc_m_frame is held from LOAD through the end of SEND.

Optional Feature:
- Macro SCHED_STATS_EN.
- Defined: adds outputs cnt_timeout[15:0] and cnt_error[15:0], which increment on each RECORD with code 01 or 10 respectively. Both saturate at 16'hFFFF and clear on reset only.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Entries 0 = 16'h3012 and 1 = 16'h4020, rest skipped; enable = 1; model returns enc/dec frame_over 200 cycles apart, no error. Expect enc_data 16'h3012 then 16'h4020, each with enc_fifo_we high 30 cycles followed by enc_send_frame high 30 cycles. Expect stat_valid with index 0 and 1, code 00, and one cycle_start per 100000 cycles.
- Entry 2 = 16'h1005; decoder never responds. Expect stat_index 2 and stat_code 01 exactly 4000 cycles (+2 sync cycles) after the enc_frame_over edge, and no hang.
- Decoder asserts dec_error with frame_over on entry 0. Expect stat_code 10; with SCHED_STATS_EN, cnt_error = 1.
- PERIOD_US = 10 with 8 active entries whose scan exceeds 10 µs. Expect an overrun pulse and an immediate cycle_start with no idle gap.
- RESET low during SEND. Expect all outputs 0 asynchronously; after release, the scan restarts from idx 0 and the table reads back 16'hF000.
- enable dropped during WAIT_RX of entry 1. Expect entry 1 reported, then busy = 0 and no further enc_fifo_we.
